// File: rtl/paint_brush_ctrl.sv
// paint_brush_ctrl: latches brush settings and streams clipped square stamps or full-screen clears to the VGA plot port.
module paint_brush_ctrl #(
  parameter int COLOUR_W = 3,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int SIZE_W = 2,
  parameter logic [COLOUR_W-1:0] DEF_COLOUR = 3'b111,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [COLOUR_W-1:0] sw_colour,
  input  logic [SIZE_W-1:0]   sw_size,
  input  logic [1:0]          sw_mode,
  input  logic                load,
  input  logic [X_W-1:0]      cursor_x,
  input  logic [Y_W-1:0]      cursor_y,
  input  logic                stamp,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);
  typedef enum logic [1:0] {IDLE, STAMP, CLEAR, FIN} state_t;
  localparam logic [X_W-1:0] XM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YM = Y_W'(Y_MAX);
  state_t state_q, state_d;
  logic [COLOUR_W-1:0] colour_q, colour_d, col_q, col_d;
  logic [SIZE_W-1:0] size_q, size_d, dx_q, dx_d, dy_q, dy_d;
  logic [1:0] mode_q, mode_d;
  logic [X_W-1:0] bx_q, bx_d, cx_q, cx_d, vx_q, vx_d;
  logic [Y_W-1:0] by_q, by_d, cy_q, cy_d, vy_q, vy_d;
  logic end_q, end_d, busy_q, busy_d, done_q, done_d, plot_q, plot_d;
  logic [X_W:0] px;
  logic [Y_W:0] py;
  logic ready;
  always_comb begin
    ready = state_q == IDLE || state_q == FIN;
    px = {1'b0, bx_q} + {{(X_W+1-SIZE_W){1'b0}}, dx_q};
    py = {1'b0, by_q} + {{(Y_W+1-SIZE_W){1'b0}}, dy_q};
    state_d = state_q;
    colour_d = colour_q;
    size_d = size_q;
    mode_d = mode_q;
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    cx_d = cx_q;
    cy_d = cy_q;
    vx_d = vx_q;
    vy_d = vy_q;
    col_d = col_q;
    end_d = end_q;
    done_d = 1'b0;
    plot_d = 1'b0;
    if (ready) begin
      if (load) begin
        colour_d = sw_colour;
        size_d = sw_size;
        mode_d = sw_mode;
      end
      state_d = IDLE;
      if (stamp && mode_d != 2'd3) begin
        state_d = mode_d == 2'd2 ? CLEAR : STAMP;
        bx_d = cursor_x;
        by_d = cursor_y;
        dx_d = '0;
        dy_d = '0;
        cx_d = '0;
        cy_d = '0;
        end_d = 1'b0;
      end
    end else if (end_q) begin
      // last pixel is already on the port; this edge raises done
      state_d = FIN;
      done_d = 1'b1;
    end else if (state_q == STAMP) begin
      vx_d = px[X_W-1:0];
      vy_d = py[Y_W-1:0];
      plot_d = px <= {1'b0, XM} && py <= {1'b0, YM};
      col_d = mode_q == 2'd1 ? BG_COLOUR : colour_q;
      dx_d = dx_q == size_q ? '0 : dx_q + 1'b1;
      dy_d = dx_q == size_q ? dy_q + 1'b1 : dy_q;
      end_d = dx_q == size_q && dy_q == size_q;
    end else begin
      vx_d = cx_q;
      vy_d = cy_q;
      plot_d = 1'b1;
      col_d = BG_COLOUR;
      cx_d = cx_q == XM ? '0 : cx_q + 1'b1;
      cy_d = cx_q == XM ? cy_q + 1'b1 : cy_q;
      end_d = cx_q == XM && cy_q == YM;
    end
    busy_d = state_d == STAMP || state_d == CLEAR;
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      colour_q <= DEF_COLOUR;
      size_q <= '0;
      mode_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      vx_q <= '0;
      vy_q <= '0;
      col_q <= '0;
      end_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      plot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      colour_q <= colour_d;
      size_q <= size_d;
      mode_q <= mode_d;
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      vx_q <= vx_d;
      vy_q <= vy_d;
      col_q <= col_d;
      end_q <= end_d;
      busy_q <= busy_d;
      done_q <= done_d;
      plot_q <= plot_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign vga_x = vx_q;
  assign vga_y = vy_q;
  assign vga_colour = col_q;
  assign vga_plot = plot_q;
endmodule

// File: tb/tb_paint_brush_ctrl.sv
// tb_paint_brush_ctrl: randomized scoreboard bench; a reference model queues expected plots, a monitor checks them.
module tb_paint_brush_ctrl;
  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  logic [2:0] sw_colour = '0;
  logic [1:0] sw_size = '0;
  logic [1:0] sw_mode = '0;
  logic load = 1'b0;
  logic [7:0] cursor_x = '0;
  logic [6:0] cursor_y = '0;
  logic stamp = 1'b0;
  logic busy, done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  paint_brush_ctrl dut (
    .Clock(Clock), .Resetn(Resetn), .sw_colour(sw_colour), .sw_size(sw_size),
    .sw_mode(sw_mode), .load(load), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .stamp(stamp), .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot)
  );
  always #5 Clock = ~Clock;
  logic [17:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] mc = 3'b111;
  logic [1:0] ms = 2'd0;
  logic [1:0] mm = 2'd0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask
  always @(negedge Clock) begin
    if (Resetn && vga_plot) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0h expected no plot", vga_x, vga_y, vga_colour);
      end else begin
        chk("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(exp_q.pop_front()));
      end
    end
  end
  task automatic run(input logic [7:0] x, input logic [6:0] y, input bit ld,
                     input logic [2:0] c, input logic [1:0] s, input logic [1:0] m);
    int n;
    logic [2:0] col;
    @(negedge Clock);
    cursor_x = x; cursor_y = y; sw_colour = c; sw_size = s; sw_mode = m; load = ld; stamp = 1'b1;
    if (ld) begin mc = c; ms = s; mm = m; end
    col = mm == 2'd1 ? 3'b000 : mc;
    n = 0;
    if (mm == 2'd2) begin
      n = 160 * 120;
      for (int yy = 0; yy < 120; yy++)
        for (int xx = 0; xx < 160; xx++) exp_q.push_back({8'(xx), 7'(yy), 3'b000});
    end else if (mm != 2'd3) begin
      n = (int'(ms) + 1) * (int'(ms) + 1);
      for (int yy = 0; yy <= int'(ms); yy++)
        for (int xx = 0; xx <= int'(ms); xx++)
          if (int'(x) + xx <= 159 && int'(y) + yy <= 119)
            exp_q.push_back({8'(int'(x) + xx), 7'(int'(y) + yy), col});
    end
    @(posedge Clock); #1;
    stamp = 1'b0; load = 1'b0;
    chk("busy_start", 32'(busy), 32'(n != 0));
    if (n == 0) begin
      repeat (3) begin
        @(posedge Clock); #1;
        chk("ignored_busy", 32'(busy), 0);
        chk("ignored_done", 32'(done), 0);
      end
      return;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #1;
      chk("busy_run", 32'({busy, done}), 32'(2'b10));
      cursor_x = 8'($urandom); cursor_y = 7'($urandom);
      sw_colour = 3'($urandom); sw_size = 2'($urandom); sw_mode = 2'($urandom);
      load = i == 1;
      stamp = i == 1 && n >= 4;
    end
    @(posedge Clock); #1;
    chk("done_pulse", 32'({done, busy, vga_plot}), 32'(3'b100));
    @(posedge Clock); #1;
    chk("done_clear", 32'({done, busy}), 0);
  endtask
  initial begin
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_plot", 32'(vga_plot), 0);
    chk("rst_xyc", 32'({vga_x, vga_y, vga_colour}), 0);
    @(negedge Clock); Resetn = 1'b1;
    run(8'd10, 7'd20, 0, 3'd0, 2'd0, 2'd0);
    run(8'd5, 7'd5, 1, 3'b100, 2'd3, 2'd0);
    run(8'd158, 7'd118, 1, 3'($urandom), 2'd3, 2'd0);
    run(8'd0, 7'd0, 1, 3'($urandom), 2'd1, 2'd1);
    run(8'd7, 7'd7, 1, 3'($urandom), 2'd2, 2'd3);
    run(8'd0, 7'd0, 1, 3'b101, 2'd2, 2'd2);
    run(8'd12, 7'd34, 0, 3'd0, 2'd0, 2'd0);
    for (int t = 0; t < 24; t++) begin
      int r;
      logic [7:0] x;
      logic [6:0] y;
      r = $urandom_range(0, 5);
      x = $urandom_range(0, 1) ? 8'($urandom_range(150, 159)) : 8'($urandom_range(0, 159));
      y = $urandom_range(0, 1) ? 7'($urandom_range(110, 119)) : 7'($urandom_range(0, 119));
      run(x, y, t == 0 || $urandom_range(0, 1) == 1, 3'($urandom), 2'($urandom),
          r < 3 ? 2'd0 : r < 5 ? 2'd1 : 2'd3);
    end
    @(negedge Clock);
    cursor_x = 8'd5; cursor_y = 7'd5; sw_colour = 3'b010; sw_size = 2'd3; sw_mode = 2'd0;
    load = 1'b1; stamp = 1'b1;
    for (int yy = 0; yy < 3; yy++) exp_q.push_back({8'(5 + yy), 7'd5, 3'b010});
    @(posedge Clock); #1;
    load = 1'b0; stamp = 1'b0;
    repeat (4) @(posedge Clock);
    #2 Resetn = 1'b0;
    #1;
    chk("abort_outputs", 32'({vga_plot, busy, done}), 0);
    chk("abort_xyc", 32'({vga_x, vga_y, vga_colour}), 0);
    exp_q.delete();
    mc = 3'b111; ms = 2'd0; mm = 2'd0;
    @(negedge Clock); Resetn = 1'b1;
    run(8'd30, 7'd40, 0, 3'd0, 2'd3, 2'd1);
    repeat (2) @(posedge Clock);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
